pixel_frame_writer: RTL and testbench
=====================================

// Module: pixel_frame_writer
// PURPOSE
//  Write-side counterpart of the image streamer: accepts a 24-bit RGB pixel stream
//  (valid/ready, start-of-frame flag) and writes one whole frame into a selected
//  image slot of a shared frame store, through a single-port write interface.
//  Sits between the capture/processing pipeline and the frame-store RAM.
// PARAMETERS
//  PIXEL_W       24     bits per pixel (RGB888)
//  FRAME_PIXELS  10000  pixels per frame (100x100)
//  NUM_SLOTS     4      image slots in the frame store, numbered 1..NUM_SLOTS
//  ADDR_W        16     frame-store word address width; must hold NUM_SLOTS*FRAME_PIXELS
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        1-cycle request to capture one frame into image_number
//  image_number  in   3        target slot, sampled when start is accepted
//  pix_valid     in   1        pixel present
//  pix_sof       in   1        qualifies the pixel as first of a frame
//  pix_data      in   PIXEL_W  pixel value
//  pix_ready     out  1        pixel accepted when pix_valid && pix_ready
//  mem_we        out  1        write request to frame store
//  mem_addr      out  ADDR_W   word address = (slot-1)*FRAME_PIXELS + pixel index
//  mem_wdata     out  PIXEL_W  write data
//  mem_ready     in   1        write completes in a cycle where mem_we && mem_ready
//  busy          out  1        high in ARMED or WRITE, or while a write is pending
//  frame_done    out  1        1-cycle pulse when the last pixel's write completes
//  err_slot      out  1        1-cycle pulse: start with image_number 0 or >NUM_SLOTS
//  err_short     out  1        1-cycle pulse: pix_sof arrived before frame complete
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pixel counter 0; slot register 0.
//  FSM: IDLE, ARMED, WRITE, DRAIN.
//   IDLE: start with valid slot -> latch slot, ARMED; start with bad slot -> err_slot, stay.
//   ARMED: pix_ready per rule below; accepted pixels with pix_sof=0 are discarded
//    (no write); accepted pixel with pix_sof=1 is written at index 0 -> WRITE.
//   WRITE: each accepted pixel written at next index. Pixel at index FRAME_PIXELS-1
//    -> DRAIN. Accepted pix_sof=1 here: err_short pulse, counter restarts, pixel
//    written at index 0, stay in WRITE.
//   DRAIN: pix_ready=0; when last write completes -> frame_done pulse same cycle as
//    the completing edge's following cycle (registered), -> IDLE.
//  start outside IDLE is ignored (no error, no state change).
//  Output stage: one registered write slot. pix_ready = (ARMED|WRITE) &&
//   (!mem_we || mem_ready). Accept->mem_we latency exactly 1 cycle; mem_addr/
//   mem_wdata held stable while mem_we && !mem_ready. Full throughput 1 pixel/clk
//   when mem_ready stays high.
//  Address: (slot-1)*FRAME_PIXELS + index, computed in ADDR_W bits; slot base
//   registered at start, index counter never exceeds FRAME_PIXELS-1 (no wrap).
//  Reset asserted mid-frame: immediate return to IDLE, mem_we drops, frame abandoned.
// STRUCTURE
//  Shared package: PIXEL_W, FRAME_PIXELS, NUM_SLOTS, ADDR_W constants and the FSM
//   state encoding (shared with the image streamer so slot/address maps agree).
//  One sub-module: pfw_addr_gen (slot base latch + pixel index counter + last flag).
// TESTING
//  1 start, image_number=2, 10000 pixels sof on first, mem_ready=1 -> 10000 writes
//    addr 10000..19999 back-to-back, frame_done 1 pulse, busy low after.
//  2 start image_number=0 and 5 -> err_slot pulse each, state stays IDLE, no writes.
//  3 ARMED, 3 pixels sof=0 then sof=1 value 0xABCDEF -> first write addr 0 data 0xABCDEF.
//  4 mem_ready toggled 1/0 every cycle -> addr/data held during stalls, no pixel lost,
//    pix_ready low while stalled, 10000 writes total.
//  5 sof at index 500 -> err_short pulse, next write at slot base+0, frame then
//    completes with 10000 further writes.
//  6 rst_n low at index 4000 -> outputs 0 asynchronously; new start works from index 0.

Source files
------------

// File: rtl/pixel_frame_writer_pkg.sv
// Shared constants, FSM encoding and slot address helpers for the frame-store
// writer (and the image streamer that reads the same slots back).
package pixel_frame_writer_pkg;

  localparam int PIXEL_W      = 24;
  localparam int FRAME_PIXELS = 10000;
  localparam int NUM_SLOTS    = 4;
  localparam int ADDR_W       = 16;
  localparam int SLOT_W       = 3;
  localparam int IDX_W        = $clog2(FRAME_PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2,
    ST_DRAIN = 2'd3
  } pfw_state_e;

  // Slots are numbered from 1; 0 and anything above NUM_SLOTS are rejected.
  function automatic logic slot_valid(input logic [SLOT_W-1:0] slot);
    return (slot != '0) && (32'(slot) <= 32'(NUM_SLOTS));
  endfunction

  function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_W-1:0] slot);
    return ADDR_W'((32'(slot) - 32'd1) * 32'(FRAME_PIXELS));
  endfunction

endpackage

// File: rtl/pfw_addr_gen.sv
// Slot base latch plus pixel index counter; produces the frame-store address
// of the pixel being accepted this cycle and flags the last pixel of a frame.
module pfw_addr_gen
  import pixel_frame_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [SLOT_W-1:0] slot,
  input  logic              restart,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cur_idx;

  // A start-of-frame pixel always lands at index 0, whatever idx holds.
  assign cur_idx = restart ? '0 : idx;
  assign last    = (cur_idx == LAST_IDX);
  assign addr    = base + ADDR_W'(cur_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
      idx  <= '0;
    end else if (load) begin
      base <= slot_base(slot);
      idx  <= '0;
    end else if (restart || advance) begin
      idx <= last ? '0 : cur_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pixel_frame_writer.sv
// Captures one RGB frame from a valid/ready pixel stream into a selected slot
// of the frame store through a single registered write port.
//
// Handshakes: a pixel transfers on a rising edge where pix_valid && pix_ready;
// a frame-store write completes on a rising edge where mem_we && mem_ready, and
// mem_addr/mem_wdata stay stable from mem_we rising until that edge.
module pixel_frame_writer
  import pixel_frame_writer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         image_number,
  input  logic               pix_valid,
  input  logic               pix_sof,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic               pix_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [PIXEL_W-1:0] mem_wdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               err_slot,
  output logic               err_short,
  output logic [1:0]         dbg_state
);

  pfw_state_e state, state_nxt;

  logic              accept;
  logic              load;
  logic              restart;
  logic              advance;
  logic              do_write;
  logic              last;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_done_nxt;
  logic              err_slot_nxt;
  logic              err_short_nxt;

  assign pix_ready = ((state == ST_ARMED) || (state == ST_WRITE)) && (!mem_we || mem_ready);
  assign accept    = pix_valid && pix_ready;
  assign load      = (state == ST_IDLE) && start && slot_valid(image_number);
  // Non-SOF pixels seen while ARMED are consumed but never written.
  assign restart   = accept && pix_sof;
  assign advance   = accept && !pix_sof && (state == ST_WRITE);
  assign do_write  = restart || advance;
  assign busy      = (state != ST_IDLE) || mem_we;
  assign dbg_state = state;

  pfw_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .slot    (image_number),
    .restart (restart),
    .advance (advance),
    .addr    (wr_addr),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    err_slot_nxt   = 1'b0;
    err_short_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (load) state_nxt = ST_ARMED;
          else      err_slot_nxt = 1'b1;
        end
      end
      ST_ARMED: begin
        if (restart) state_nxt = last ? ST_DRAIN : ST_WRITE;
      end
      ST_WRITE: begin
        if (restart) err_short_nxt = 1'b1;
        if (do_write && last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!mem_we || mem_ready) begin
          frame_done_nxt = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status pulses are registered, so each appears the cycle after its cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      err_slot   <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      frame_done <= frame_done_nxt;
      err_slot   <= err_slot_nxt;
      err_short  <= err_short_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (do_write) begin
      mem_we    <= 1'b1;
      mem_addr  <= wr_addr;
      mem_wdata <= pix_data;
    end else if (mem_ready) begin
      mem_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer: full frames, slot errors, SOF hunting,
// write-port stalls, short frames and mid-frame reset.
module tb_pixel_frame_writer;
  import pixel_frame_writer_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [2:0]         image_number = 3'd0;
  logic               pix_valid = 1'b0;
  logic               pix_sof = 1'b0;
  logic [PIXEL_W-1:0] pix_data = '0;
  logic               pix_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [PIXEL_W-1:0] mem_wdata;
  logic               mem_ready;
  logic               busy;
  logic               frame_done;
  logic               err_slot;
  logic               err_short;
  logic [1:0]         dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int drv_timeouts = 0;
  bit toggle_mode = 1'b0;

  logic [ADDR_W+PIXEL_W-1:0] exp_q[$];
  logic [ADDR_W+PIXEL_W-1:0] act_q[$];
  int act_t[$];
  int cyc = 0;
  int done_cnt = 0;
  int err_slot_cnt = 0;
  int err_short_cnt = 0;
  int hold_err = 0;
  int ready_err = 0;
  int stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [ADDR_W+PIXEL_W-1:0] held = '0;

  pixel_frame_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .image_number (image_number),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_slot     (err_slot),
    .err_short    (err_short),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / frame-store model ----------------
  always #5 clk = ~clk;

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = toggle_mode ? ~mem_ready : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Observation at the falling edge: records completed writes and pulses.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_we && mem_ready) begin
        act_q.push_back({mem_addr, mem_wdata});
        act_t.push_back(cyc);
      end
      if (frame_done) done_cnt++;
      if (err_slot) err_slot_cnt++;
      if (err_short) err_short_cnt++;
      if (prev_stall && mem_we && ({mem_addr, mem_wdata} != held)) hold_err++;
      if (mem_we && !mem_ready && pix_ready) ready_err++;
      if (mem_we && !mem_ready) stall_cnt++;
      prev_stall = mem_we && !mem_ready;
      held = {mem_addr, mem_wdata};
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [PIXEL_W-1:0] pix_val(input int i, input int seed);
    return PIXEL_W'(i * 32'h0001_0307 + seed * 32'h0050_0000);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [2:0] slot);
    start = 1'b1;
    image_number = slot;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic sof, input logic [PIXEL_W-1:0] d);
    int n;
    if (drv_timeouts > 3) return;
    n = 0;
    pix_valid = 1'b1;
    pix_sof = sof;
    pix_data = d;
    @(negedge clk);
    while (!pix_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!pix_ready) drv_timeouts++;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) drv_timeouts++;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({pix_ready, mem_we, busy, frame_done, err_slot, err_short} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 000000", {pix_ready, mem_we, busy, frame_done, err_slot, err_short});
    end
    n_cmp++;
    if (mem_addr !== 16'd0 || mem_wdata !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr %0d data %h, expected 0 / 000000", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, expected 0", dbg_state);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    int a0, d0, t0;
    a0 = act_q.size();
    d0 = done_cnt;
    t0 = drv_timeouts;
    exp_q.delete();
    pulse_start(3'd2);
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      send_pixel(i == 0, pix_val(i, 1));
      exp_q.push_back({16'(10000 + i), pix_val(i, 1)});
    end
    wait_idle(50);
    n_cmp++;
    if (drv_timeouts !== t0) begin
      n_fail++;
      $display("FAIL full_timeout: got %0d handshake timeouts, expected 0", drv_timeouts - t0);
    end
    n_cmp++;
    if (act_q.size() - a0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes, expected %0d", act_q.size() - a0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && a0 + k < act_q.size(); k++) begin
      n_cmp++;
      if (act_q[a0+k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL full_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 k, act_q[a0+k][39:24], act_q[a0+k][23:0], exp_q[k][39:24], exp_q[k][23:0]);
      end
    end
    if (act_q.size() - a0 >= 10000) begin
      n_cmp++;
      if (act_t[a0+9999] - act_t[a0] != 9999) begin
        n_fail++;
        $display("FAIL full_throughput: got %0d cycles first-to-last write, expected 9999", act_t[a0+9999] - act_t[a0]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL full_done: got %0d frame_done pulses, expected 1", done_cnt - d0);
    end
    n_cmp++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL full_idle: got busy %b state %0d, expected busy 0 state 0", busy, dbg_state);
    end
  endtask

  task automatic test_bad_slot();
    int a0, e0;
    a0 = act_q.size();
    e0 = err_slot_cnt;
    pulse_start(3'd0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (err_slot_cnt - e0 != 1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL bad_slot0: got %0d err pulses state %0d, expected 1 pulse state 0", err_slot_cnt - e0, dbg_state);
    end
    pulse_start(3'd5);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (err_slot_cnt - e0 != 2 || dbg_state !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_slot5: got %0d err pulses state %0d busy %b, expected 2 / 0 / 0",
               err_slot_cnt - e0, dbg_state, busy);
    end
    n_cmp++;
    if (act_q.size() != a0) begin
      n_fail++;
      $display("FAIL bad_slot_writes: got %0d writes, expected 0", act_q.size() - a0);
    end
  endtask

  task automatic test_sof_hunt();
    int a0, e0;
    a0 = act_q.size();
    e0 = err_slot_cnt;
    pulse_start(3'd1);
    pulse_start(3'd0);
    pulse_start(3'd3);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dbg_state !== 2'd1 || err_slot_cnt != e0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hunt_armed: got state %0d err pulses %0d busy %b, expected 1 / 0 / 1",
               dbg_state, err_slot_cnt - e0, busy);
    end
    send_pixel(1'b0, 24'h111111);
    send_pixel(1'b0, 24'h222222);
    send_pixel(1'b0, 24'h333333);
    n_cmp++;
    if (mem_we !== 1'b0 || act_q.size() != a0 || dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL hunt_discard: got mem_we %b writes %0d state %0d, expected 0 / 0 / 1",
               mem_we, act_q.size() - a0, dbg_state);
    end
    send_pixel(1'b1, 24'hABCDEF);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (act_q.size() - a0 != 1) begin
      n_fail++;
      $display("FAIL hunt_count: got %0d writes, expected 1", act_q.size() - a0);
    end
    if (act_q.size() > a0) begin
      n_cmp++;
      if (act_q[a0] !== {16'd0, 24'hABCDEF}) begin
        n_fail++;
        $display("FAIL hunt_first: got addr %0d data %h, expected addr 0 data abcdef", act_q[a0][39:24], act_q[a0][23:0]);
      end
    end
    n_cmp++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL hunt_write_state: got %0d, expected 2", dbg_state);
    end
    do_reset();
  endtask

  task automatic test_stall();
    int a0, d0, h0, r0, s0, t0;
    a0 = act_q.size();
    d0 = done_cnt;
    h0 = hold_err;
    r0 = ready_err;
    s0 = stall_cnt;
    t0 = drv_timeouts;
    exp_q.delete();
    toggle_mode = 1'b1;
    pulse_start(3'd3);
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      send_pixel(i == 0, pix_val(i, 2));
      exp_q.push_back({16'(20000 + i), pix_val(i, 2)});
    end
    wait_idle(50);
    toggle_mode = 1'b0;
    n_cmp++;
    if (drv_timeouts !== t0) begin
      n_fail++;
      $display("FAIL stall_timeout: got %0d handshake timeouts, expected 0", drv_timeouts - t0);
    end
    n_cmp++;
    if (act_q.size() - a0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_count: got %0d writes, expected %0d", act_q.size() - a0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && a0 + k < act_q.size(); k++) begin
      n_cmp++;
      if (act_q[a0+k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stall_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 k, act_q[a0+k][39:24], act_q[a0+k][23:0], exp_q[k][39:24], exp_q[k][23:0]);
      end
    end
    n_cmp++;
    if (stall_cnt == s0) begin
      n_fail++;
      $display("FAIL stall_seen: got 0 stalled cycles, expected at least 1");
    end
    n_cmp++;
    if (hold_err != h0) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d addr/data changes during stall, expected 0", hold_err - h0);
    end
    n_cmp++;
    if (ready_err != r0) begin
      n_fail++;
      $display("FAIL stall_ready: got %0d cycles pix_ready high while stalled, expected 0", ready_err - r0);
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: got %0d pulses busy %b, expected 1 / 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_short_frame();
    int a0, d0, e0, t0;
    a0 = act_q.size();
    d0 = done_cnt;
    e0 = err_short_cnt;
    t0 = drv_timeouts;
    exp_q.delete();
    pulse_start(3'd4);
    for (int i = 0; i < 500; i++) begin
      send_pixel(i == 0, pix_val(i, 3));
      exp_q.push_back({16'(30000 + i), pix_val(i, 3)});
    end
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      send_pixel(i == 0, pix_val(i, 4));
      exp_q.push_back({16'(30000 + i), pix_val(i, 4)});
    end
    wait_idle(50);
    n_cmp++;
    if (drv_timeouts !== t0) begin
      n_fail++;
      $display("FAIL short_timeout: got %0d handshake timeouts, expected 0", drv_timeouts - t0);
    end
    n_cmp++;
    if (err_short_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL short_err: got %0d err_short pulses, expected 1", err_short_cnt - e0);
    end
    n_cmp++;
    if (act_q.size() - a0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL short_count: got %0d writes, expected %0d", act_q.size() - a0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && a0 + k < act_q.size(); k++) begin
      n_cmp++;
      if (act_q[a0+k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL short_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 k, act_q[a0+k][39:24], act_q[a0+k][23:0], exp_q[k][39:24], exp_q[k][23:0]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL short_done: got %0d frame_done pulses, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int a0;
    a0 = act_q.size();
    exp_q.delete();
    pulse_start(3'd1);
    for (int i = 0; i < 4000; i++) begin
      send_pixel(i == 0, pix_val(i, 5));
      if (i < 3999) exp_q.push_back({16'(i), pix_val(i, 5)});
    end
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pending: got mem_we %b before reset, expected 1", mem_we);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, busy, pix_ready} !== 3'b000 || mem_addr !== 16'd0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got we/busy/ready %b addr %0d state %0d, expected 000 / 0 / 0",
               {mem_we, busy, pix_ready}, mem_addr, dbg_state);
    end
    n_cmp++;
    if (act_q.size() - a0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d writes, expected %0d", act_q.size() - a0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && a0 + k < act_q.size(); k++) begin
      n_cmp++;
      if (act_q[a0+k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL midrst_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 k, act_q[a0+k][39:24], act_q[a0+k][23:0], exp_q[k][39:24], exp_q[k][23:0]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a0 = act_q.size();
    pulse_start(3'd1);
    send_pixel(1'b1, 24'h0A0B0C);
    send_pixel(1'b0, 24'h0D0E0F);
    send_pixel(1'b0, 24'h102030);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (act_q.size() - a0 != 3) begin
      n_fail++;
      $display("FAIL restart_count: got %0d writes, expected 3", act_q.size() - a0);
    end
    if (act_q.size() - a0 >= 3) begin
      n_cmp++;
      if (act_q[a0] !== {16'd0, 24'h0A0B0C} || act_q[a0+1] !== {16'd1, 24'h0D0E0F} ||
          act_q[a0+2] !== {16'd2, 24'h102030}) begin
        n_fail++;
        $display("FAIL restart_writes: got %h %h %h, expected 00000a0b0c 00010d0e0f 0002102030",
                 act_q[a0], act_q[a0+1], act_q[a0+2]);
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_bad_slot();
    test_sof_hunt();
    test_stall();
    test_short_frame();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
